// File: rtl/lock_if.sv
// Keypad-lock pin bundle: raw buttons and code switches in, lock status out.
// The master modport is the pad/driver side, the slave modport is the sequencer.
interface lock_if;
  logic       set_btn;
  logic       check_btn;
  logic [6:0] code_in;
  logic [2:0] state;
  logic       unlocked;
  logic       alarm_blink;
  logic       locked_out;
  logic [2:0] fail_count;

  modport master (
    output set_btn, check_btn, code_in,
    input  state, unlocked, alarm_blink, locked_out, fail_count
  );

  modport slave (
    input  set_btn, check_btn, code_in,
    output state, unlocked, alarm_blink, locked_out, fail_count
  );
endinterface

// File: rtl/lock_sequencer.sv
// Keypad lock sequencer: synchronizes and edge-detects the set/check buttons,
// holds the password, counts consecutive failures with a timed lockout and
// drives the alarm blink. Synchronous active-high reset.
// Optional feature: define LOCK_AUTORELOCK_EN to return OPENED to IDLE after
// OPEN_CYCLES cycles without a button press.
module lock_sequencer #(
  parameter logic [6:0]  RESET_CODE     = 7'h00,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned OPEN_CYCLES    = 4096,
  parameter int unsigned BLINK_W        = 9
) (
  input logic   clk,
  input logic   rst,
  lock_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StSetAwait = 3'b001,
    StOpened   = 3'b010,
    StAlarm    = 3'b011,
    StInput    = 3'b100,
    StLockout  = 3'b101
  } state_e;

  localparam bit ParamsOk = (MAX_FAILS >= 1) && (MAX_FAILS <= 7) &&
                            (LOCKOUT_CYCLES >= 1) && (LOCKOUT_CYCLES <= 65536) &&
                            (OPEN_CYCLES >= 1) && (OPEN_CYCLES <= 65536) &&
                            (BLINK_W >= 1);

  if (!ParamsOk) begin : g_param_err
    $error("lock_sequencer: parameter out of legal range");
  end

  localparam logic [3:0]  MaxFails = 4'(MAX_FAILS);
  localparam logic [15:0] LockLoad = 16'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_AUTORELOCK_EN
  localparam logic [15:0] OpenLoad = 16'(OPEN_CYCLES - 1);
`endif

  // Button synchronizers and edge detectors.
  logic set_s1_q, set_s2_q, set_prev_q;
  logic chk_s1_q, chk_s2_q, chk_prev_q;
  logic set_pulse, chk_pulse;

  // FSM and datapath state.
  state_e              state_q, state_d;
  logic [6:0]          pwd_q, pwd_d;
  logic [2:0]          fail_q, fail_d;
  logic [15:0]         timer_q, timer_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic [3:0]          fail_inc;
  logic                unlocked_q, alarm_q, locked_q;

  // Two-flop synchronizer plus previous-value flop per button.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_s1_q   <= 1'b0;
      set_s2_q   <= 1'b0;
      set_prev_q <= 1'b0;
      chk_s1_q   <= 1'b0;
      chk_s2_q   <= 1'b0;
      chk_prev_q <= 1'b0;
    end else begin
      set_s1_q   <= bus.set_btn;
      set_s2_q   <= set_s1_q;
      set_prev_q <= set_s2_q;
      chk_s1_q   <= bus.check_btn;
      chk_s2_q   <= chk_s1_q;
      chk_prev_q <= chk_s2_q;
    end
  end

  // Check wins over set when both pulse together.
  assign chk_pulse = chk_s2_q & ~chk_prev_q;
  assign set_pulse = set_s2_q & ~set_prev_q & ~chk_pulse;

  assign fail_inc = {1'b0, fail_q} + 4'd1;
  assign blink_d  = blink_q + {{(BLINK_W-1){1'b0}}, 1'b1};

  // Next-state logic for the lock FSM, password, failure count and timer.
  always_comb begin
    state_d = state_q;
    pwd_d   = pwd_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (chk_pulse) state_d = StInput;
      end
      StInput: begin
        if (chk_pulse) begin
          if (bus.code_in == pwd_q) begin
            state_d = StOpened;
            fail_d  = 3'd0;
`ifdef LOCK_AUTORELOCK_EN
            timer_d = OpenLoad;
`endif
          end else if (fail_inc >= MaxFails) begin
            state_d = StLockout;
            fail_d  = 3'd0;
            timer_d = LockLoad;
          end else begin
            state_d = StAlarm;
            fail_d  = fail_inc[2:0];
          end
        end
      end
      StOpened: begin
`ifdef LOCK_AUTORELOCK_EN
        if (chk_pulse || set_pulse) begin
          timer_d = OpenLoad;
        end else if (timer_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 16'd1;
        end
`endif
        if (chk_pulse) begin
          state_d = StIdle;
        end else if (set_pulse) begin
          state_d = StSetAwait;
        end
      end
      StSetAwait: begin
        if (chk_pulse) begin
          state_d = StIdle;
        end else if (set_pulse) begin
          pwd_d   = bus.code_in;
          state_d = StIdle;
        end
      end
      StAlarm: begin
        if (chk_pulse) state_d = StIdle;
      end
      StLockout: begin
        if (timer_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM registers; status outputs are registered from the next state so they
  // always agree with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pwd_q      <= RESET_CODE;
      fail_q     <= 3'd0;
      timer_q    <= 16'd0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwd_q      <= pwd_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      unlocked_q <= (state_d == StOpened);
      alarm_q    <= (state_d == StAlarm) & blink_d[BLINK_W-1];
      locked_q   <= (state_d == StLockout);
    end
  end

  // Free-running blink counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.unlocked    = unlocked_q;
  assign bus.alarm_blink = alarm_q;
  assign bus.locked_out  = locked_q;
  assign bus.fail_count  = fail_q;

endmodule
